pipe_run_ctrl: RTL
==================

# pipe_run_ctrl

Run/halt/single-step sequencer for the 8-bit four-stage pipeline (IF, ID, EX, WB). It drives fetch advance, bubble insertion and pipeline-register enable from a valid/ready command port. Halts always drain in-flight instructions, so the register file is never left with a partial write. It also keeps a retired-instruction count for the debug host and supports an optional PC breakpoint.

## Interface
Parameters:
- PC_W, 8, width of the fetch PC and breakpoint address.
- DRAIN_CYCLES, 3, cycles from fetch to writeback (IF/ID, ID/EX, EX/WB); must be ≥1.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready at a rising edge.
- cmd_op  in  2  00 NOP, 01 RUN, 10 HALT, 11 STEP.
- cmd_count  in  8  STEP instruction count.
- pc  in  PC_W  address fetched this cycle.
- bp_addr  in  PC_W  breakpoint address (BP build only).
- bp_en  in  1  breakpoint arm (BP build only).
- fetch_en  out  1  fetch unit advances PC; instruction is issued.
- bubble  out  1  forces regwrite=0 into IF/ID (NOP issue).
- pipe_en  out  1  all pipeline registers advance.
- halted  out  1  in HALTED state.
- done  out  1  one-cycle pulse on HALTED entry.
- bp_hit  out  1  one-cycle pulse when a breakpoint stops RUN (0 without BP).
- retired_cnt  out  16  instructions that reached WB.

## Operation
- States: HALTED, RUN, STEP, DRAIN; 2-bit encoding.
- HALTED:
  - fetch_en=0, bubble=1, pipe_en=0, cmd_ready=1.
  - RUN → RUN. HALT/NOP → no-op.
  - STEP with cmd_count=N>0 → STEP, step_cnt=N. STEP with N=0 → stays HALTED, done pulses next cycle.
- RUN:
  - fetch_en=1, bubble=0, pipe_en=1, cmd_ready=1.
  - HALT → DRAIN. RUN/STEP/NOP accepted and ignored.
- STEP:
  - fetch_en=1, bubble=0, pipe_en=1, cmd_ready=0.
  - step_cnt decrements each cycle; at step_cnt==1 → DRAIN.
  - Exactly N instructions are issued.
- DRAIN:
  - fetch_en=0, bubble=1, pipe_en=1, cmd_ready=0.
  - drain_cnt is loaded DRAIN_CYCLES-1 on entry; → HALTED when drain_cnt==0.
  - DRAIN lasts exactly DRAIN_CYCLES cycles.
- Retire tracking:
  - DRAIN_CYCLES-bit shift register issue_sr shifts in fetch_en when pipe_en=1.
  - When the bit shifted out is 1, retired_cnt += 1, wrapping at 16 bits.
  - HALTED entry always finds issue_sr all-zero.
- Reset: state HALTED; step_cnt, drain_cnt, issue_sr, retired_cnt = 0; done=0, bp_hit=0, halted=1. Outputs are as HALTED from the first cycle after reset. Reset mid-RUN/STEP/DRAIN abandons in-flight tracking and does not pulse done.

## Timing
- Command accepted at edge k: new state's outputs apply from cycle k+1. The acceptance cycle keeps the old state's outputs.
- RUN→HALT at edge k: cycles k+1..k+DRAIN_CYCLES are DRAIN. halted=1 and done=1 in cycle k+DRAIN_CYCLES+1.
- STEP N accepted at edge k: fetch cycles k+1..k+N, drain k+N+1..k+N+DRAIN_CYCLES, done at k+N+DRAIN_CYCLES+1.
- fetch_en, bubble and pipe_en are Moore-decoded from state, except for the breakpoint suppression below (Mealy on pc).
- retired_cnt is registered and updates the edge after the retiring WB cycle.

## Configuration
- PIPE_RUN_CTRL_BP_EN defined:
  - In RUN, when bp_en & pc==bp_addr, that cycle has fetch_en=0 and bubble=1, so the breakpoint instruction is not issued.
  - State → DRAIN at that edge; bp_hit pulses the following cycle.
  - Breakpoint is ignored in STEP, so a STEP can move past it.
  - A HALT accepted in the same cycle as a breakpoint match gives one DRAIN entry and bp_hit=1.
- Undefined: bp_addr and bp_en are ignored, the comparator is not built, and bp_hit is tied 0.

## Test plan
- Reset then idle 10 cycles → halted=1, pipe_en=0, bubble=1, retired_cnt=0, cmd_ready=1.
- STEP count=5 from HALTED → fetch_en high exactly 5 cycles, then 3 DRAIN cycles, done pulse once, retired_cnt=5, cmd_ready low throughout.
- RUN, wait 20 cycles, HALT → fetch_en high 21 cycles (acceptance cycle included), DRAIN 3 cycles, retired_cnt=21; a STEP offered during DRAIN stays unaccepted until HALTED.
- BP build: bp_en=1, bp_addr=0x07, pc counts from 0, RUN → fetch_en low at pc=0x07, bp_hit pulse, retired_cnt=7. A following STEP 1 issues pc 0x07 and gives retired_cnt=8.
- STEP count=0 → no fetch_en; done pulses the cycle after acceptance; retired_cnt unchanged.
- rst asserted on the 2nd DRAIN cycle → next cycle HALTED, retired_cnt=0, no done pulse, issue_sr empty; a subsequent STEP 2 → retired_cnt=2.

Source files
------------

// File: rtl/pipe_run_ctrl.sv
// Run/halt/single-step sequencer for the 4-stage pipeline with retire count.
// Optional PC breakpoint built when PIPE_RUN_CTRL_BP_EN is defined.
module pipe_run_ctrl #(
  parameter int PC_W         = 8,
  parameter int DRAIN_CYCLES = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [1:0]      cmd_op,
  input  logic [7:0]      cmd_count,
  input  logic [PC_W-1:0] pc,
  input  logic [PC_W-1:0] bp_addr,
  input  logic            bp_en,
  output logic            fetch_en,
  output logic            bubble,
  output logic            pipe_en,
  output logic            halted,
  output logic            done,
  output logic            bp_hit,
  output logic [15:0]     retired_cnt
);

  localparam int CW =
    (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [CW-1:0] DRAIN_LOAD =
    CW'(DRAIN_CYCLES - 1);

  localparam logic [1:0] OP_RUN  = 2'b01;
  localparam logic [1:0] OP_HALT = 2'b10;
  localparam logic [1:0] OP_STEP = 2'b11;

  typedef enum logic [1:0] {
    S_HALTED,
    S_RUN,
    S_STEP,
    S_DRAIN
  } state_t;

  state_t state_q, state_d;
  logic [7:0]    step_q, step_d;
  logic [CW-1:0] drain_q, drain_d;
  logic          done_d;
  logic          accept;
  logic          bp_match;
  logic [DRAIN_CYCLES-1:0] issue_sr_q;
  logic [DRAIN_CYCLES:0]   sr_shift;

`ifdef PIPE_RUN_CTRL_BP_EN
  assign bp_match = bp_en && (state_q == S_RUN)
                    && (pc == bp_addr);

  always_ff @(posedge clk) begin
    if (rst) bp_hit <= 1'b0;
    else     bp_hit <= bp_match;
  end
`else
  logic unused_bp;
  assign unused_bp = ^{bp_en, bp_addr, pc};
  assign bp_match  = 1'b0;
  assign bp_hit    = 1'b0;
`endif

  always_comb begin
    cmd_ready = (state_q == S_HALTED) || (state_q == S_RUN);
    accept    = cmd_valid && cmd_ready;
    fetch_en  = ((state_q == S_RUN) && !bp_match)
                || (state_q == S_STEP);
    bubble    = !fetch_en;
    pipe_en   = (state_q != S_HALTED);
    halted    = (state_q == S_HALTED);
  end

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    drain_d = drain_q;
    done_d  = 1'b0;
    unique case (state_q)
      S_HALTED: begin
        if (accept && cmd_op == OP_RUN) begin
          state_d = S_RUN;
        end else if (accept && cmd_op == OP_STEP) begin
          if (cmd_count != 8'd0) begin
            state_d = S_STEP;
            step_d  = cmd_count;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      S_RUN: begin
        if (bp_match || (accept && cmd_op == OP_HALT)) begin
          state_d = S_DRAIN;
          drain_d = DRAIN_LOAD;
        end
      end
      S_STEP: begin
        step_d = step_q - 8'd1;
        if (step_q == 8'd1) begin
          state_d = S_DRAIN;
          drain_d = DRAIN_LOAD;
        end
      end
      S_DRAIN: begin
        if (drain_q == '0) begin
          state_d = S_HALTED;
          done_d  = 1'b1;
        end else begin
          drain_d = drain_q - 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_HALTED;
      step_q  <= '0;
      drain_q <= '0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      drain_q <= drain_d;
      done    <= done_d;
    end
  end

  // Top bit is the instruction leaving WB this cycle.
  assign sr_shift = {issue_sr_q, fetch_en};

  always_ff @(posedge clk) begin
    if (rst) begin
      issue_sr_q  <= '0;
      retired_cnt <= '0;
    end else if (pipe_en) begin
      issue_sr_q <= sr_shift[DRAIN_CYCLES-1:0];
      if (sr_shift[DRAIN_CYCLES])
        retired_cnt <= retired_cnt + 16'd1;
    end
  end

endmodule
